// File: rtl/riscv_mem_subsys.sv
// riscv_mem_subsys
// Unified single-ported word memory shared by an instruction-fetch port and
// a data port.  One access is in flight at a time.  Simultaneous requests
// are arbitrated round-robin, and every access takes LATENCY wait cycles
// before a single response cycle.
//
// Parameters
//   DATA_W  : word width in bits (multiple of 8)
//   DEPTH   : number of words (power of two)
//   LATENCY : wait cycles per access (0..7)
//
// Ports
//   clk, rst        : clock, asynchronous active-low reset
//   i_req, i_addr   : fetch request (held until i_ack) and byte address
//   i_rdata, i_ack  : fetch data and one-cycle completion pulse
//   d_req, d_we,    : data request (held until d_ack), write enable,
//   d_be, d_addr,   : byte enables, byte address
//   d_wdata         : and write data
//   d_rdata, d_ack  : data read data and one-cycle completion pulse
//   err             : access fault, valid together with the ack
//   busy            : high while an access occupies the memory
module riscv_mem_subsys #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [31:0]         i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [31:0]         d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                err,
  output logic                busy
);

  localparam int          NB         = DATA_W / 8;
  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state;
  logic [2:0]          cnt;
  logic                last_instr;
  logic                sel_data;
  logic [31:0]         lat_addr;
  logic                lat_we;
  logic [NB-1:0]       lat_be;
  logic [DATA_W-1:0]   lat_wdata;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                any_req;
  logic                grant_data;
  logic                acc_data;
  logic [31:0]         acc_addr;
  logic                acc_we;
  logic [NB-1:0]       acc_be;
  logic [DATA_W-1:0]   acc_wdata;
  logic                acc_fault;
  logic [AW-1:0]       acc_idx;
  logic                enter_resp;
  logic                do_write;

  // The memory is touched on the edge that enters RESP.  With LATENCY=0 that
  // edge is the grant edge itself, so the access attributes come straight
  // from the port being granted; otherwise they come from the latched copy.
  // The data port wins a tie only when the instruction port was served last.
  always_comb begin
    any_req    = i_req | d_req;
    grant_data = d_req & (~i_req | last_instr);
    acc_data   = sel_data;
    acc_addr   = lat_addr;
    acc_we     = lat_we;
    acc_be     = lat_be;
    acc_wdata  = lat_wdata;
    if (state == IDLE) begin
      acc_data = grant_data;
      if (grant_data) begin
        acc_addr  = d_addr;
        acc_we    = d_we;
        acc_be    = d_be;
        acc_wdata = d_wdata;
      end else begin
        acc_addr  = i_addr;
        acc_we    = 1'b0;
        acc_be    = '0;
        acc_wdata = '0;
      end
    end
    acc_fault  = (acc_addr[1:0] != 2'b00) || (acc_addr >= ADDR_LIMIT);
    acc_idx    = acc_addr[AW+1:2];
    enter_resp = ((state == IDLE) && any_req && (LATENCY == 0)) ||
                 ((state == WAIT) && (cnt == 3'd1));
    do_write   = enter_resp && acc_data && acc_we && !acc_fault;
  end

  // Array has no reset so its contents survive a reset pulse.  The rst term
  // blocks a write on an edge where reset is being held.
  always_ff @(posedge clk) begin
    if (do_write && rst) begin
      for (int b = 0; b < NB; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  // Control FSM with registered responses.  Response outputs default to 0
  // every cycle so data, ack and err are only ever seen in the RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_instr <= 1'b1;
      sel_data   <= 1'b0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_be     <= '0;
      lat_wdata  <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      err     <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            sel_data   <= grant_data;
            last_instr <= ~grant_data;
            lat_addr   <= acc_addr;
            lat_we     <= acc_we;
            lat_be     <= acc_be;
            lat_wdata  <= acc_wdata;
            cnt        <= 3'(LATENCY);
            busy       <= 1'b1;
            state      <= (LATENCY == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RESP;
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Faulting accesses and writes return zero data.
      if (enter_resp) begin
        err <= acc_fault;
        if (acc_data) begin
          d_ack <= 1'b1;
          if (!acc_fault && !acc_we) d_rdata <= mem[acc_idx];
        end else begin
          i_ack <= 1'b1;
          if (!acc_fault) i_rdata <= mem[acc_idx];
        end
      end
    end
  end

endmodule

// File: doc/riscv_mem_subsys.md
RISCV_MEM_SUBSYS -- requirements
Module: riscv_mem_subsys

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
 DATA_W, 32, word width in bits; multiple of 8.
 DEPTH, 64, number of words; power of two.
 LATENCY, 1, wait cycles per access; range 0..7.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
 clk  in  1  single clock; all state updates on rising edge.
 rst  in  1  reset; asynchronous, active-low.
 i_req  in  1  instruction-fetch request; held until i_ack.
 i_addr  in  32  fetch byte address.
 i_rdata  out  DATA_W  fetch read data; valid while i_ack=1.
 i_ack  out  1  one-cycle fetch completion pulse.
 d_req  in  1  data request; held until d_ack.
 d_we  in  1  1 = write, 0 = read.
 d_be  in  DATA_W/8  byte enables for writes.
 d_addr  in  32  data byte address.
 d_wdata  in  DATA_W  write data.
 d_rdata  out  DATA_W  data read data; valid while d_ack=1.
 d_ack  out  1  one-cycle data completion pulse.
 err  out  1  access fault; valid with the ack of the same access.
 busy  out  1  1 while an access is in progress.

Function
REQ-003 SHALL hold one unified DEPTH x DATA_W array serving both ports; one access in flight at a time.
REQ-004 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-005 IDLE: with no request, SHALL stay in IDLE.
REQ-006 IDLE: with any request, SHALL grant one port, latch its address, d_we, d_be and d_wdata, and load the wait counter with LATENCY.
REQ-007 On grant, SHALL enter WAIT if LATENCY>0, else RESP.
REQ-008 WAIT: SHALL decrement the counter each cycle and enter RESP on the edge where the counter is 1.
REQ-009 On the edge entering RESP, SHALL perform the access and register the read data, err and the granted port's ack.
REQ-010 RESP: SHALL assert exactly one ack for exactly one cycle, then return to IDLE; no new grant in the RESP cycle.
REQ-011 Latency: request sampled in IDLE at cycle N SHALL give ack in cycle N+1+LATENCY; back-to-back grants SHALL be 2+LATENCY cycles apart.
REQ-012 Arbitration SHALL be round-robin on simultaneous requests. A last-grant pointer starts at instr after reset, so data wins the first tie.
REQ-013 A lone requester SHALL be granted regardless of the pointer.
REQ-014 Word index SHALL be addr[log2(DEPTH)+1:2].
REQ-015 Fault SHALL be addr[1:0]!=0 or addr >= 4*DEPTH.
REQ-016 On fault, SHALL assert err with the ack, drive the read data 0, and suppress any write.
REQ-017 Writes SHALL update only the bytes whose d_be bit is 1; d_be=0 SHALL leave the array unchanged and still ack.
REQ-018 Reads SHALL return the full word; d_be is ignored for reads.
REQ-019 Outside its ack cycle, i_rdata/d_rdata SHALL be 0 and err SHALL be 0.
REQ-020 busy SHALL be 1 in WAIT and RESP and 0 in IDLE.
REQ-021 Request inputs SHALL be sampled only in IDLE; changes during WAIT/RESP SHALL be ignored.
REQ-022 A request dropped before its ack SHALL still complete and ack.

Reset
REQ-023 rst=0 SHALL immediately force state IDLE, counter 0, pointer to instr, and i_ack, d_ack, err, busy, i_rdata, d_rdata all 0.
REQ-024 Reset asserted before the RESP-entry edge SHALL abort the access with no write and no ack.
REQ-025 Array contents SHALL NOT be cleared by reset.
REQ-026 After rst rises, the first grant SHALL occur no earlier than the first rising edge with rst=1.

Verification
REQ-027 LATENCY=1, data write 0x11223344 to 0x8 with d_be=1111, then instr fetch of 0x8 -> d_ack 2 cycles after grant; i_rdata=0x11223344 with i_ack.
REQ-028 Word 0x8 = 0x11223344; write 0xAABBCCDD with d_be=0101, then read -> d_rdata=0x11BB33DD.
REQ-029 i_req and d_req held high together for 4 accesses -> grant order data, instr, data, instr; acks 3 cycles apart.
REQ-030 Read of 0x6 (misaligned) and read of 0x100 (DEPTH=64) -> err=1 with d_ack, d_rdata=0, array unchanged.
REQ-031 LATENCY=3, write issued, rst pulsed low during WAIT -> no d_ack, busy=0 immediately, target word keeps its old value.
REQ-032 LATENCY=0, single fetch -> i_ack in the cycle after the request is sampled; busy high for exactly 1 cycle.
